// File: rtl/mem_arb_pkg.sv
// Purpose : shared types and constants for the memory port arbiter.
// Latency : n/a (package only).
// Backpressure : n/a (package only).
//
// Contents: FSM state encoding, memory size codes (these match the data
// memory's dsize encoding), and the latency/starvation counter width.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT_I = 2'd1,
    ST_WAIT_D = 2'd2
  } arb_state_t;

  localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
  localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
  localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

  // Wide enough for MEM_LAT-1 with MEM_LAT up to 15, and for the
  // starvation count.
  localparam int CNT_W = 4;
  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Purpose : picks the winner of an IDLE-cycle arbitration between fetch and data.
// Latency : combinational pick; the optional starvation count updates on clk.
// Backpressure : no pick unless arb_en (FSM idle and not in reset).
//
// Optional feature macro: ARB_STARVE_GUARD_EN (adds the starvation counter
// and the clk/reset ports it needs).
// Ports:
//   clk, reset     clock and synchronous active-low reset (guard build only)
//   arb_en         arbitration allowed this cycle
//   i_req, d_req   pending fetch / data requests
//   pick_i, pick_d one-hot winner (both 0 when nothing is granted)
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
`ifdef ARB_STARVE_GUARD_EN
  input  logic clk,
  input  logic reset,
`endif
  input  logic arb_en,
  input  logic i_req,
  input  logic d_req,
  output logic pick_i,
  output logic pick_d
);

  logic starve;

`ifdef ARB_STARVE_GUARD_EN
  localparam cnt_t STARVE_LIM = CNT_W'(STARVE_MAX);

  cnt_t starve_cnt;

  // Fetch is forced through once data has won STARVE_MAX times in a row
  // while fetch was waiting.
  assign starve = i_req && (starve_cnt == STARVE_LIM);

  always_ff @(posedge clk) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (arb_en) begin
      if (pick_i || !i_req) begin
        starve_cnt <= '0;
      end else if (pick_d) begin
        starve_cnt <= starve_cnt + cnt_t'(1);
      end
    end
  end
`else
  assign starve = 1'b0;
`endif

  always_comb begin
    pick_i = 1'b0;
    pick_d = 1'b0;
    if (arb_en) begin
      pick_d = d_req && !starve;
      pick_i = i_req && (!d_req || starve);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Purpose : shares one single-ported data memory between fetch and load/store.
// Latency : gnt combinational in the issue cycle T; rvalid at T+MEM_LAT.
// Backpressure : one transaction at a time; requests stay pending (no gnt) while busy.
//
// Optional feature macro: ARB_STARVE_GUARD_EN (forces a fetch grant after
// STARVE_MAX consecutive data grants that overtook a pending fetch).
// Ports:
//   clk, reset                     clock, synchronous active-low reset
//   i_req/i_addr -> i_gnt          fetch request and accept pulse
//   i_rvalid/i_rdata               fetched word return
//   d_req/d_we/d_size/d_sign/d_addr/d_wdata -> d_gnt   data request and accept
//   d_rvalid/d_rdata               load data or store completion (rdata 0)
//   m_addr/m_wdata/m_we/m_size/m_sign, m_rdata         memory side
//   busy                           transaction outstanding
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic        d_sign,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic        m_we,
  output logic [1:0]  m_size,
  output logic        m_sign,
  input  logic [31:0] m_rdata,
  output logic        busy
);

  localparam cnt_t LAT_INIT = CNT_W'(MEM_LAT - 1);

  arb_state_t  state, state_nxt;
  cnt_t        lat_cnt, lat_cnt_nxt;

  logic [31:0] hold_addr;
  logic [31:0] hold_wdata;
  logic [1:0]  hold_size;
  logic        hold_sign;
  logic        hold_we;

  logic        arb_en;
  logic        pick_i;
  logic        pick_d;
  logic        waiting;
  logic        done;

  // Gating with reset keeps every output at 0 while reset is held, even
  // though gnt and m_* are combinational from the request inputs.
  assign arb_en  = reset && (state == ST_IDLE);
  assign waiting = reset && (state != ST_IDLE);
  assign done    = waiting && (lat_cnt == '0);

  mem_arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
`ifdef ARB_STARVE_GUARD_EN
    .clk    (clk),
    .reset  (reset),
`endif
    .arb_en (arb_en),
    .i_req  (i_req),
    .d_req  (d_req),
    .pick_i (pick_i),
    .pick_d (pick_d)
  );

  // Next state and latency counter.
  always_comb begin
    state_nxt   = state;
    lat_cnt_nxt = lat_cnt;
    case (state)
      ST_IDLE: begin
        if (pick_d) begin
          state_nxt   = ST_WAIT_D;
          lat_cnt_nxt = LAT_INIT;
        end else if (pick_i) begin
          state_nxt   = ST_WAIT_I;
          lat_cnt_nxt = LAT_INIT;
        end
      end
      ST_WAIT_I, ST_WAIT_D: begin
        if (lat_cnt == '0) begin
          state_nxt = ST_IDLE;
        end else begin
          lat_cnt_nxt = lat_cnt - cnt_t'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= ST_IDLE;
      lat_cnt <= '0;
    end else begin
      state   <= state_nxt;
      lat_cnt <= lat_cnt_nxt;
    end
  end

  // Hold registers replay the issued request on m_* for the wait cycles.
  // A fetch is captured as a plain word read.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hold_addr  <= '0;
      hold_wdata <= '0;
      hold_size  <= '0;
      hold_sign  <= 1'b0;
      hold_we    <= 1'b0;
    end else if (pick_d) begin
      hold_addr  <= d_addr;
      hold_wdata <= d_wdata;
      hold_size  <= d_size;
      hold_sign  <= d_sign;
      hold_we    <= d_we;
    end else if (pick_i) begin
      hold_addr  <= i_addr;
      hold_wdata <= '0;
      hold_size  <= MEM_SIZE_WORD;
      hold_sign  <= 1'b0;
      hold_we    <= 1'b0;
    end
  end

  // Memory-side drive: live winner in the issue cycle, hold registers while
  // waiting, zero otherwise. m_we only ever pulses in the issue cycle.
  always_comb begin
    m_addr  = '0;
    m_wdata = '0;
    m_we    = 1'b0;
    m_size  = '0;
    m_sign  = 1'b0;
    if (pick_d) begin
      m_addr  = d_addr;
      m_wdata = d_wdata;
      m_we    = d_we;
      m_size  = d_size;
      m_sign  = d_sign;
    end else if (pick_i) begin
      m_addr  = i_addr;
      m_size  = MEM_SIZE_WORD;
    end else if (waiting) begin
      m_addr  = hold_addr;
      m_wdata = hold_wdata;
      m_size  = hold_size;
      m_sign  = hold_sign;
    end
  end

  // Requester-side returns; rdata passes m_rdata through only in the
  // completion cycle of the owner, and a store returns 0.
  always_comb begin
    i_gnt    = pick_i;
    d_gnt    = pick_d;
    i_rvalid = done && (state == ST_WAIT_I);
    d_rvalid = done && (state == ST_WAIT_D);
    i_rdata  = '0;
    d_rdata  = '0;
    busy     = waiting;
    if (i_rvalid) begin
      i_rdata = m_rdata;
    end
    if (d_rvalid && !hold_we) begin
      d_rdata = m_rdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Table-driven bench for mem_port_arbiter (MEM_LAT=2) plus a MEM_LAT=1 instance.
module tb_mem_port_arbiter;

  typedef struct {
    logic        rst;
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic        dwe;
    logic [1:0]  dsz;
    logic        dsg;
    logic [31:0] da;
    logic [31:0] dwd;
    logic [31:0] mrd;
  } in_t;

  typedef struct {
    logic        ig;
    logic        dg;
    logic        iv;
    logic        dv;
    logic [31:0] ird;
    logic [31:0] drd;
    logic [31:0] ma;
    logic [31:0] mwd;
    logic        mwe;
    logic [1:0]  msz;
    logic        msg;
    logic        bsy;
  } exp_t;

  typedef struct {
    in_t  i;
    exp_t e;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Main DUT, MEM_LAT = 2.
  logic        reset = 1'b0;
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, d_sign = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, m_rdata = '0;
  logic [1:0]  d_size = '0;
  logic        i_gnt, i_rvalid, d_gnt, d_rvalid, m_we, m_sign, busy;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic [1:0]  m_size;

  mem_port_arbiter #(.MEM_LAT(2), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_sign(d_sign), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we), .m_size(m_size), .m_sign(m_sign),
    .m_rdata(m_rdata), .busy(busy)
  );

  // Second DUT, MEM_LAT = 1, fetch side only.
  logic        b_i_req = 1'b0, b_d_req = 1'b0, b_d_we = 1'b0, b_d_sign = 1'b0;
  logic [31:0] b_i_addr = '0, b_d_addr = '0, b_d_wdata = '0, b_m_rdata = '0;
  logic [1:0]  b_d_size = '0;
  logic        b_i_gnt, b_i_rvalid, b_d_gnt, b_d_rvalid, b_m_we, b_m_sign, b_busy;
  logic [31:0] b_i_rdata, b_d_rdata, b_m_addr, b_m_wdata;
  logic [1:0]  b_m_size;

  mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) dut_lat1 (
    .clk(clk), .reset(reset),
    .i_req(b_i_req), .i_addr(b_i_addr), .i_gnt(b_i_gnt), .i_rvalid(b_i_rvalid),
    .i_rdata(b_i_rdata), .d_req(b_d_req), .d_we(b_d_we), .d_size(b_d_size),
    .d_sign(b_d_sign), .d_addr(b_d_addr), .d_wdata(b_d_wdata), .d_gnt(b_d_gnt),
    .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata), .m_addr(b_m_addr), .m_wdata(b_m_wdata),
    .m_we(b_m_we), .m_size(b_m_size), .m_sign(b_m_sign), .m_rdata(b_m_rdata),
    .busy(b_busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One cycle: drive on the falling edge, sample 1 ns later.
  task automatic step(input vec_t v, input string tag);
    @(negedge clk);
    reset   = v.i.rst;
    i_req   = v.i.ir;
    i_addr  = v.i.ia;
    d_req   = v.i.dr;
    d_we    = v.i.dwe;
    d_size  = v.i.dsz;
    d_sign  = v.i.dsg;
    d_addr  = v.i.da;
    d_wdata = v.i.dwd;
    m_rdata = v.i.mrd;
    #1;
    chk({tag, " i_gnt"},    32'(i_gnt),    32'(v.e.ig));
    chk({tag, " d_gnt"},    32'(d_gnt),    32'(v.e.dg));
    chk({tag, " i_rvalid"}, 32'(i_rvalid), 32'(v.e.iv));
    chk({tag, " d_rvalid"}, 32'(d_rvalid), 32'(v.e.dv));
    chk({tag, " i_rdata"},  i_rdata,       v.e.ird);
    chk({tag, " d_rdata"},  d_rdata,       v.e.drd);
    chk({tag, " m_addr"},   m_addr,        v.e.ma);
    chk({tag, " m_wdata"},  m_wdata,       v.e.mwd);
    chk({tag, " m_we"},     32'(m_we),     32'(v.e.mwe));
    chk({tag, " m_size"},   32'(m_size),   32'(v.e.msz));
    chk({tag, " m_sign"},   32'(m_sign),   32'(v.e.msg));
    chk({tag, " busy"},     32'(busy),     32'(v.e.bsy));
  endtask

  vec_t tbl[16];
  vec_t rst_seq[7];
  exp_t e0;
  in_t  idle_in;

  initial begin
    int gkind[6];
    int ng;
    int n_ig;
    int n_dg;
    logic [5:0] exp_bg;
    logic [5:0] exp_bv;

    e0      = '{default: 0};
    idle_in = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0};

    // Reset with requests active, then fetch read.
    tbl[0]  = '{'{0, 1, 32'h100, 1, 1, 2'd2, 1, 32'h40, 32'h99, 32'h55}, e0};
    tbl[1]  = '{'{0, 0, 32'h0, 0, 0, 2'd0, 0, 32'h0, 32'h0, 32'h0}, e0};
    tbl[2]  = '{'{1, 1, 32'h100, 0, 0, 2'd0, 0, 32'h0, 32'h0, 32'h0},
                '{1, 0, 0, 0, 32'h0, 32'h0, 32'h100, 32'h0, 0, 2'd2, 0, 0}};
    tbl[3]  = '{idle_in, '{0, 0, 0, 0, 32'h0, 32'h0, 32'h100, 32'h0, 0, 2'd2, 0, 1}};
    tbl[4]  = '{'{1, 0, 32'h0, 0, 0, 2'd0, 0, 32'h0, 32'h0, 32'hDEADBEEF},
                '{0, 0, 1, 0, 32'hDEADBEEF, 32'h0, 32'h100, 32'h0, 0, 2'd2, 0, 1}};
    tbl[5]  = '{'{1, 0, 32'h0, 0, 0, 2'd0, 0, 32'h0, 32'h0, 32'hDEADBEEF}, e0};
    // Simultaneous fetch and signed half-word load: data first.
    tbl[6]  = '{'{1, 1, 32'h200, 1, 0, 2'd1, 1, 32'h2000, 32'h0, 32'h0},
                '{0, 1, 0, 0, 32'h0, 32'h0, 32'h2000, 32'h0, 0, 2'd1, 1, 0}};
    tbl[7]  = '{'{1, 1, 32'h200, 0, 0, 2'd0, 0, 32'h0, 32'h0, 32'h0},
                '{0, 0, 0, 0, 32'h0, 32'h0, 32'h2000, 32'h0, 0, 2'd1, 1, 1}};
    tbl[8]  = '{'{1, 1, 32'h200, 0, 0, 2'd0, 0, 32'h0, 32'h0, 32'hCAFEF00D},
                '{0, 0, 0, 1, 32'h0, 32'hCAFEF00D, 32'h2000, 32'h0, 0, 2'd1, 1, 1}};
    tbl[9]  = '{'{1, 1, 32'h200, 0, 0, 2'd0, 0, 32'h0, 32'h0, 32'h0},
                '{1, 0, 0, 0, 32'h0, 32'h0, 32'h200, 32'h0, 0, 2'd2, 0, 0}};
    tbl[10] = '{idle_in, '{0, 0, 0, 0, 32'h0, 32'h0, 32'h200, 32'h0, 0, 2'd2, 0, 1}};
    tbl[11] = '{'{1, 0, 32'h0, 0, 0, 2'd0, 0, 32'h0, 32'h0, 32'h11223344},
                '{0, 0, 1, 0, 32'h11223344, 32'h0, 32'h200, 32'h0, 0, 2'd2, 0, 1}};
    // Store; d_req held into the wait cycle must not be granted again.
    tbl[12] = '{'{1, 0, 32'h0, 1, 1, 2'd2, 0, 32'h40, 32'h12345678, 32'h0},
                '{0, 1, 0, 0, 32'h0, 32'h0, 32'h40, 32'h12345678, 1, 2'd2, 0, 0}};
    tbl[13] = '{'{1, 0, 32'h0, 1, 1, 2'd2, 0, 32'h40, 32'h12345678, 32'hFFFFFFFF},
                '{0, 0, 0, 0, 32'h0, 32'h0, 32'h40, 32'h12345678, 0, 2'd2, 0, 1}};
    tbl[14] = '{'{1, 0, 32'h0, 0, 0, 2'd0, 0, 32'h0, 32'h0, 32'hFFFFFFFF},
                '{0, 0, 0, 1, 32'h0, 32'h0, 32'h40, 32'h12345678, 0, 2'd2, 0, 1}};
    tbl[15] = '{idle_in, e0};

    for (int k = 0; k < 16; k++) step(tbl[k], $sformatf("v%0d", k));

    // Reset one cycle after a load issue: transaction abandoned, no rvalid.
    rst_seq[0] = '{'{1, 0, 32'h0, 1, 0, 2'd0, 0, 32'h3000, 32'h0, 32'h0},
                   '{0, 1, 0, 0, 32'h0, 32'h0, 32'h3000, 32'h0, 0, 2'd0, 0, 0}};
    rst_seq[1] = '{'{0, 0, 32'h0, 0, 0, 2'd0, 0, 32'h0, 32'h0, 32'hAAAA5555}, e0};
    rst_seq[2] = '{'{0, 0, 32'h0, 1, 0, 2'd0, 0, 32'h3008, 32'h0, 32'hAAAA5555}, e0};
    rst_seq[3] = '{'{1, 0, 32'h0, 1, 0, 2'd2, 0, 32'h3004, 32'h0, 32'h0},
                   '{0, 1, 0, 0, 32'h0, 32'h0, 32'h3004, 32'h0, 0, 2'd2, 0, 0}};
    rst_seq[4] = '{idle_in, '{0, 0, 0, 0, 32'h0, 32'h0, 32'h3004, 32'h0, 0, 2'd2, 0, 1}};
    rst_seq[5] = '{'{1, 0, 32'h0, 0, 0, 2'd0, 0, 32'h0, 32'h0, 32'h77},
                   '{0, 0, 0, 1, 32'h0, 32'h77, 32'h3004, 32'h0, 0, 2'd2, 0, 1}};
    rst_seq[6] = '{idle_in, e0};
    for (int k = 0; k < 7; k++) step(rst_seq[k], $sformatf("rst%0d", k));

    // Starvation: both requests held for 50 cycles.
    ng   = 0;
    n_ig = 0;
    n_dg = 0;
    for (int k = 0; k < 6; k++) gkind[k] = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      i_req = 1'b1; i_addr = 32'h500;
      d_req = 1'b1; d_we = 1'b0; d_size = 2'd2; d_addr = 32'h600;
      m_rdata = 32'h0;
      #1;
      if (i_gnt) n_ig++;
      if (d_gnt) n_dg++;
      if ((i_gnt || d_gnt) && ng < 6) begin
        gkind[ng] = i_gnt ? 2 : 1;
        ng++;
      end
    end
`ifdef ARB_STARVE_GUARD_EN
    chk("starve g0", 32'(gkind[0]), 32'd1);
    chk("starve g1", 32'(gkind[1]), 32'd1);
    chk("starve g2", 32'(gkind[2]), 32'd1);
    chk("starve g3", 32'(gkind[3]), 32'd1);
    chk("starve g4", 32'(gkind[4]), 32'd2);
    chk("starve g5", 32'(gkind[5]), 32'd1);
`else
    chk("starve i_gnt count", 32'(n_ig), 32'd0);
    chk("starve d_gnt count", 32'(n_dg), 32'd17);
    chk("starve first grant", 32'(gkind[0]), 32'd1);
`endif
    @(negedge clk);
    i_req = 1'b0; d_req = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("post starve busy", 32'(busy), 32'd0);

    // MEM_LAT=1 back-to-back fetches.
    exp_bg = 6'b010101;
    exp_bv = 6'b101010;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      b_i_req   = 1'b1;
      b_i_addr  = 32'h400;
      b_m_rdata = 32'h1000 + 32'(c);
      #1;
      chk($sformatf("lat1 c%0d i_gnt", c), 32'(b_i_gnt), 32'(exp_bg[c]));
      chk($sformatf("lat1 c%0d i_rvalid", c), 32'(b_i_rvalid), 32'(exp_bv[c]));
      chk($sformatf("lat1 c%0d i_rdata", c), b_i_rdata, exp_bv[c] ? 32'h1000 + 32'(c) : 32'h0);
      chk($sformatf("lat1 c%0d m_addr", c), b_m_addr, 32'h400);
    end
    @(negedge clk);
    b_i_req = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
